// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared encodings and defaults for the execute-stage sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int          c_flush_cycles_def = 2;
  localparam int          c_hold_timeout_def = 255;
  localparam int          c_flush_cnt_w      = 4;
  localparam int          c_wdog_w           = 16;
  // Instruction the IF/ID and ID/EX registers load when flushed (addi x0,x0,0)
  localparam logic [31:0] c_nop_insn         = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_wdog.sv
// ============================================================================
// pipe_ctrl_wdog : consecutive-HOLD cycle counter with sticky timeout flag
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int HOLD_TIMEOUT = c_hold_timeout_def
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_hold,
  output logic timeout
);

  logic [c_wdog_w-1:0] r_cnt;
  logic [c_wdog_w-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (!in_hold) begin
      w_cnt_next = '0;
    end else if (r_cnt != {c_wdog_w{1'b1}}) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  generate
    if (HOLD_TIMEOUT != 0) begin : g_wdog_en
      localparam logic [c_wdog_w-1:0] c_limit = c_wdog_w'(HOLD_TIMEOUT);
      logic r_flag;

      // Flag sets on the edge that closes the HOLD_TIMEOUT-th HOLD cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_flag <= 1'b0;
        end else if (in_hold && (w_cnt_next == c_limit)) begin
          r_flag <= 1'b1;
        end
      end

      assign timeout = r_flag;
    end else begin : g_wdog_dis
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : EX-stage sequencer producing PC redirect, flush and stall
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = c_flush_cycles_def,
  parameter int HOLD_TIMEOUT = c_hold_timeout_def,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_ex_i,
  input  logic              hold_bus_i,
  output logic              pc_load_o,
  output logic [ADDR_W-1:0] pc_addr_o,
  output logic              flush_o,
  output logic              pipe_hold_o,
  output logic              hold_timeout_o,
  output logic [1:0]        state_o
);

  localparam logic [c_flush_cnt_w-1:0] c_flush_load = c_flush_cnt_w'(FLUSH_CYCLES - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [c_flush_cnt_w-1:0] r_flush_cnt;
  logic [c_flush_cnt_w-1:0] w_flush_cnt_next;
  logic                     r_pend;
  logic                     w_pend_next;
  logic [ADDR_W-1:0]        r_pend_addr;
  logic [ADDR_W-1:0]        w_pend_addr_next;
  logic [ADDR_W-1:0]        r_pc_addr;
  logic [ADDR_W-1:0]        w_pc_addr_next;
  logic                     r_pc_load;
  logic                     w_pc_load_next;
  logic                     w_hold_any;
  logic                     w_pipe_hold;

  assign w_hold_any = hold_ex_i | hold_bus_i;

  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_pend_next      = r_pend;
    w_pend_addr_next = r_pend_addr;
    w_pc_addr_next   = r_pc_addr;
    w_pc_load_next   = 1'b0;
    w_pipe_hold      = 1'b0;

    case (r_state)
      ST_RUN: begin
        w_pipe_hold = w_hold_any;
        if (jump_en_i) begin
          w_pc_addr_next   = jump_addr_i;
          w_flush_cnt_next = c_flush_load;
          w_pc_load_next   = 1'b1;
          w_state_next     = ST_FLUSH;
        end else if (w_hold_any) begin
          w_state_next = ST_HOLD;
        end
      end

      ST_FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_state_next = w_hold_any ? ST_HOLD : ST_RUN;
        end else begin
          w_flush_cnt_next = r_flush_cnt - 1'b1;
        end
      end

      ST_HOLD: begin
        w_pipe_hold = w_hold_any;
        if (jump_en_i && !r_pend) begin
          w_pend_next      = 1'b1;
          w_pend_addr_next = jump_addr_i;
        end
        // A jump arriving in the release cycle counts as the pending one
        if (!w_hold_any) begin
          if (r_pend || jump_en_i) begin
            w_pc_addr_next   = r_pend ? r_pend_addr : jump_addr_i;
            w_pend_next      = 1'b0;
            w_flush_cnt_next = c_flush_load;
            w_pc_load_next   = 1'b1;
            w_state_next     = ST_FLUSH;
          end else begin
            w_state_next = ST_RUN;
          end
        end
      end

      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pc_addr   <= '0;
      r_pc_load   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_pend      <= w_pend_next;
      r_pend_addr <= w_pend_addr_next;
      r_pc_addr   <= w_pc_addr_next;
      r_pc_load   <= w_pc_load_next;
    end
  end

  pipe_ctrl_wdog #(
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_hold (r_state == ST_HOLD),
    .timeout (hold_timeout_o)
  );

  assign pc_load_o   = r_pc_load;
  assign pc_addr_o   = r_pc_addr;
  assign flush_o     = (r_state == ST_FLUSH);
  // Stall is combinational from the requests; masked so reset forces it low
  assign pipe_hold_o = w_pipe_hold & rst_n;
  assign state_o     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed + random checks of pipe_ctrl against a cycle model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int FC = 2;
  localparam int TO = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          hold_ex = 1'b0;
  logic          hold_bus = 1'b0;
  logic          pc_load;
  logic [AW-1:0] pc_addr;
  logic          flush;
  logic          pipe_hold;
  logic          hold_timeout;
  logic [1:0]    state;

  pipe_ctrl #(
    .FLUSH_CYCLES(FC),
    .HOLD_TIMEOUT(TO),
    .ADDR_W      (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .jump_en_i     (jump_en),
    .jump_addr_i   (jump_addr),
    .hold_ex_i     (hold_ex),
    .hold_bus_i    (hold_bus),
    .pc_load_o     (pc_load),
    .pc_addr_o     (pc_addr),
    .flush_o       (flush),
    .pipe_hold_o   (pipe_hold),
    .hold_timeout_o(hold_timeout),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_loads  = 0;
  bit seen_200 = 1'b0;

  // Reference model: remaining flush cycles, a hold flag and a pending-target queue
  int            m_flush_left;
  bit            m_hold;
  logic [AW-1:0] m_pend_q[$];
  logic [AW-1:0] m_pc;
  bit            m_load;
  int            m_hcnt;
  bit            m_to;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_hold       = 1'b0;
    m_pend_q.delete();
    m_pc         = '0;
    m_load       = 1'b0;
    m_hcnt       = 0;
    m_to         = 1'b0;
  endtask

  task automatic model_step(input bit j, input logic [AW-1:0] a, input bit h);
    bit in_hold_now;
    in_hold_now = (m_flush_left == 0) && m_hold;
    if (in_hold_now) begin
      if (m_hcnt < 65535) m_hcnt++;
      if (m_hcnt == TO) m_to = 1'b1;
    end else begin
      m_hcnt = 0;
    end
    m_load = 1'b0;
    if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_hold = h;
    end else if (m_hold) begin
      if (j && m_pend_q.size() == 0) m_pend_q.push_back(a);
      if (!h) begin
        m_hold = 1'b0;
        if (m_pend_q.size() > 0) begin
          m_pc         = m_pend_q.pop_front();
          m_flush_left = FC;
          m_load       = 1'b1;
        end
      end
    end else if (j) begin
      m_pc         = a;
      m_flush_left = FC;
      m_load       = 1'b1;
    end else if (h) begin
      m_hold = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic [1:0] exp_state;
    bit         exp_ph;
    exp_state = (m_flush_left > 0) ? 2'd1 : (m_hold ? 2'd2 : 2'd0);
    exp_ph    = rst_n && (m_flush_left == 0) && (hold_ex || hold_bus);
    if (pc_load === 1'b1) n_loads++;
    if (pc_addr === 32'h200) seen_200 = 1'b1;
    chk("state", state, exp_state);
    chk("pc_load", pc_load, m_load);
    chk("pc_addr", pc_addr, m_pc);
    chk("flush", flush, (m_flush_left > 0));
    chk("pipe_hold", pipe_hold, exp_ph);
    chk("hold_timeout", hold_timeout, m_to);
  endtask

  task automatic cycle(input bit j, input logic [AW-1:0] a, input bit hex, input bit hbus);
    @(negedge clk);
    jump_en   = j;
    jump_addr = a;
    hold_ex   = hex;
    hold_bus  = hbus;
    #1;
    check_outputs();
    @(posedge clk);
    model_step(j, a, hex | hbus);
  endtask

  // Called right after a rising edge; pulses reset well clear of both edges
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int   base;
    bit   rh_ex;
    bit   rh_bus;
    model_reset();

    // Power-on reset
    #1 rst_n = 1'b0;
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Jump in RUN
    cycle(1, 32'h40, 0, 0);
    #1;
    chk("t2_load", pc_load, 1);
    chk("t2_addr", pc_addr, 32'h40);
    chk("t2_flush1", flush, 1);
    cycle(0, 0, 0, 0);
    #1;
    chk("t2_flush2", flush, 1);
    chk("t2_load_drop", pc_load, 0);
    cycle(0, 0, 0, 0);
    #1;
    chk("t2_state_run", state, 0);
    chk("t2_flush_end", flush, 0);

    // Jump with simultaneous hold
    base = n_loads;
    cycle(1, 32'h300, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    #1;
    chk("t3_state_hold", state, 2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    chk("t3_load_once", n_loads - base, 1);

    // Jumps during HOLD: first target wins
    seen_200 = 1'b0;
    cycle(0, 0, 1, 0);
    cycle(1, 32'h100, 1, 0);
    cycle(1, 32'h200, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    #1;
    chk("t4_load", pc_load, 1);
    chk("t4_addr", pc_addr, 32'h100);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    chk("t4_no_200", seen_200, 0);

    // Jump in second FLUSH cycle is ignored
    base = n_loads;
    cycle(1, 32'h50, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 32'h80, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    chk("t5_load_once", n_loads - base, 1);
    chk("t5_addr", pc_addr, 32'h50);

    // Asynchronous reset mid-FLUSH
    cycle(1, 32'h60, 0, 0);
    #2;
    chk("t1_pre_state", state, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_state", state, 0);
    chk("t1_flush", flush, 0);
    chk("t1_addr", pc_addr, 0);
    check_outputs();
    #1 rst_n = 1'b1;

    // Watchdog
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    #1;
    chk("t6_timeout_sticky", hold_timeout, 1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_timeout_reset", hold_timeout, 0);
    #1 rst_n = 1'b1;

    // Random traffic
    rh_ex  = 1'b0;
    rh_bus = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rh_ex = ~rh_ex;
      if ($urandom_range(0, 4) == 0) rh_bus = ~rh_bus;
      if ($urandom_range(0, 149) == 0) async_reset();
      cycle(($urandom_range(0, 4) == 0), $urandom & 32'hFFFF_FFFC, rh_ex, rh_bus);
    end
    cycle(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
